multi_way_selector_reg: RTL and testbench

Parametrised N-way, W-bit selector with a one-entry registered output and valid/ready handshake. It is the next generation of the 32-bit two-input datapath selector. It is used where the multicycle datapath needs a source choice held stable across cycles, for example the ALU operand, write-back data or next-PC source. Selection and capture happen in one cycle, and the result is held until the consumer accepts it.

---
 rtl/selector_pkg.sv | 22 ++
 rtl/multi_way_selector_reg_if.sv | 32 +++
 rtl/selector_capture_stage.sv | 88 ++++++++
 rtl/multi_way_selector_reg.sv | 72 +++++++
 tb/tb_multi_way_selector_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/selector_pkg.sv
// Shared types and constants for the multi-way registered selector.
// Also provides sel_width(), the select-field width for a given channel count.
package selector_pkg;

  localparam int SELECTOR_MAX_CHANNELS = 16;
  localparam int SELECTOR_RESET_DATA   = 0;

  typedef enum logic [0:0] {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_e;

  // A two-way selector still needs one control bit, hence the floor of 1.
  function automatic int sel_width(input int channels);
    if (channels <= 2) begin
      return 1;
    end else begin
      return $clog2(channels);
    end
  endfunction

endpackage

// File: rtl/multi_way_selector_reg_if.sv
// Producer/consumer bundle of the multi-way registered selector.
// The slave modport is the selector side; master is the producer/consumer side.
interface multi_way_selector_reg_if
  import selector_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = sel_width(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] DataInputs;
  logic [SEL_W-1:0]          Control;
  logic                      InValid;
  logic                      InReady;
  logic                      Flush;
  logic [WIDTH-1:0]          DataOutput;
  logic [SEL_W-1:0]          OutChannel;
  logic                      OutValid;
  logic                      OutReady;
  logic                      SelectError;

  modport slave (
    input  DataInputs, Control, InValid, Flush, OutReady,
    output InReady, DataOutput, OutChannel, OutValid, SelectError
  );

  modport master (
    output DataInputs, Control, InValid, Flush, OutReady,
    input  InReady, DataOutput, OutChannel, OutValid, SelectError
  );

endinterface

// File: rtl/selector_capture_stage.sv
// One-entry payload register (data + channel) with the valid/ready/flush FSM.
// Flush outranks a same-cycle accept; reset outranks everything.
module selector_capture_stage
  import selector_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_chan,
  output logic [WIDTH-1:0] out_data,
  output logic [SEL_W-1:0] out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  cap_state_e               state_r;
  cap_state_e               state_s;
  logic                     load_s;
  logic                     accept_s;
  logic                     drain_s;
  logic [WIDTH+SEL_W-1:0]   payload_r;

  // Ready never looks at in_valid, so no valid->ready loop can form upstream.
  assign in_ready  = (state_r == CAP_EMPTY) | out_ready;
  assign accept_s  = in_valid & in_ready;
  assign drain_s   = (state_r == CAP_FULL) & out_ready;
  assign out_valid = (state_r == CAP_FULL);
  assign out_data  = payload_r[SEL_W +: WIDTH];
  assign out_chan  = payload_r[SEL_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= CAP_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and payload load enable.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      CAP_EMPTY: begin
        if (accept_s && !flush) begin
          state_s = CAP_FULL;
          load_s  = 1'b1;
        end else begin
          state_s = CAP_EMPTY;
        end
      end
      CAP_FULL: begin
        if (flush) begin
          state_s = CAP_EMPTY;
        end else if (accept_s) begin
          state_s = CAP_FULL;
          load_s  = 1'b1;
        end else if (drain_s) begin
          state_s = CAP_EMPTY;
        end else begin
          state_s = CAP_FULL;
        end
      end
      default: begin
        state_s = CAP_EMPTY;
      end
    endcase
  end

  // Payload holds its last value after drain or flush; only a load changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_r <= (WIDTH+SEL_W)'(SELECTOR_RESET_DATA);
    end else if (load_s) begin
      payload_r <= {in_data, in_chan};
    end else begin
      payload_r <= payload_r;
    end
  end

endmodule

// File: rtl/multi_way_selector_reg.sv
// N-way, W-bit selector with a one-entry registered output and valid/ready handshake.
// Define SELECTOR_RANGE_CHECK_EN to build the sticky out-of-range SelectError flag.
module multi_way_selector_reg
  import selector_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                      CLK,
  input  logic                      Reset,
  multi_way_selector_reg_if.slave   bus
);

  localparam int SEL_W = sel_width(CHANNELS);

  logic [WIDTH-1:0] sel_data_s;
  logic             in_ready_s;

  // N:1 mux; a Control value with no matching channel yields all-zero data.
  always_comb begin
    sel_data_s = WIDTH'(SELECTOR_RESET_DATA);
    for (int k = 0; k < CHANNELS; k++) begin
      sel_data_s = (bus.Control == SEL_W'(k)) ? bus.DataInputs[k*WIDTH +: WIDTH] : sel_data_s;
    end
  end

  selector_capture_stage #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_capture (
    .clk       (CLK),
    .rst       (Reset),
    .in_valid  (bus.InValid),
    .in_ready  (in_ready_s),
    .flush     (bus.Flush),
    .in_data   (sel_data_s),
    .in_chan   (bus.Control),
    .out_data  (bus.DataOutput),
    .out_chan  (bus.OutChannel),
    .out_valid (bus.OutValid),
    .out_ready (bus.OutReady)
  );

  assign bus.InReady = in_ready_s;

`ifdef SELECTOR_RANGE_CHECK_EN
  localparam logic [SEL_W:0] CHANNELS_LIM = (SEL_W+1)'(CHANNELS);

  logic accept_s;
  logic out_of_range_s;
  logic select_error_r;

  assign accept_s       = bus.InValid & in_ready_s;
  assign out_of_range_s = ({1'b0, bus.Control} >= CHANNELS_LIM);

  // Sticky error: set on an out-of-range accept, cleared only by Reset (not Flush).
  always_ff @(posedge CLK) begin
    if (Reset) begin
      select_error_r <= 1'b0;
    end else if (accept_s && out_of_range_s) begin
      select_error_r <= 1'b1;
    end else begin
      select_error_r <= select_error_r;
    end
  end

  assign bus.SelectError = select_error_r;
`else
  assign bus.SelectError = 1'b0;
`endif

endmodule

// File: tb/tb_multi_way_selector_reg.sv
// Directed + randomized bench for multi_way_selector_reg: a 4-channel and a 3-channel
// instance share stimulus and are compared against a transaction-level model.
module tb_multi_way_selector_reg;

`ifdef SELECTOR_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic CLK;
  logic Reset;

  multi_way_selector_reg_if #(.WIDTH(32), .CHANNELS(4)) bus_a ();
  multi_way_selector_reg_if #(.WIDTH(32), .CHANNELS(3)) bus_b ();

  multi_way_selector_reg #(.WIDTH(32), .CHANNELS(4)) dut_a (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_a)
  );

  multi_way_selector_reg #(.WIDTH(32), .CHANNELS(3)) dut_b (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // stimulus
  logic [31:0] din [4];
  logic [1:0]  ctl;
  bit          vin, ordy, fl, rst, chk_en;

  // model: occupancy count plus the last captured payload per instance
  int          m_cnt  [2];
  logic [31:0] m_data [2];
  logic [1:0]  m_chan [2];
  bit          m_err  [2];

  int n_cmp;
  int n_fail;

  function automatic int chans(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic apply();
    bus_a.DataInputs = {din[3], din[2], din[1], din[0]};
    bus_b.DataInputs = {din[2], din[1], din[0]};
    bus_a.Control = ctl;   bus_b.Control = ctl;
    bus_a.InValid = vin;   bus_b.InValid = vin;
    bus_a.OutReady = ordy; bus_b.OutReady = ordy;
    bus_a.Flush = fl;      bus_b.Flush = fl;
    Reset = rst;
  endtask

  task automatic model_update(input int d);
    bit rdy, acc, drn;
    if (rst) begin
      m_cnt[d] = 0; m_data[d] = 32'h0; m_chan[d] = 2'd0; m_err[d] = 1'b0;
    end else begin
      rdy = (m_cnt[d] == 0) || ordy;
      acc = vin && rdy;
      drn = (m_cnt[d] != 0) && ordy;
      if (acc && int'(ctl) >= chans(d) && RC) m_err[d] = 1'b1;
      if (fl) begin
        m_cnt[d] = 0;
      end else begin
        if (drn) m_cnt[d]--;
        if (acc) begin
          m_cnt[d]++;
          m_data[d] = (int'(ctl) < chans(d)) ? din[ctl] : 32'h0;
          m_chan[d] = ctl;
        end
      end
    end
  endtask

  // Called at posedge+1: drive, check InReady mid-cycle, advance model, check outputs.
  task automatic tick();
    apply();
    #1;
    if (chk_en) begin
      check("a.InReady", {63'd0, bus_a.InReady}, {63'd0, (m_cnt[0] == 0) || ordy});
      check("b.InReady", {63'd0, bus_b.InReady}, {63'd0, (m_cnt[1] == 0) || ordy});
    end
    model_update(0);
    model_update(1);
    @(posedge CLK);
    #1;
    check("a.DataOutput",  bus_a.DataOutput,  m_data[0]);
    check("a.OutChannel",  bus_a.OutChannel,  m_chan[0]);
    check("a.OutValid",    bus_a.OutValid,    m_cnt[0] != 0);
    check("a.SelectError", bus_a.SelectError, m_err[0]);
    check("b.DataOutput",  bus_b.DataOutput,  m_data[1]);
    check("b.OutChannel",  bus_b.OutChannel,  m_chan[1]);
    check("b.OutValid",    bus_b.OutValid,    m_cnt[1] != 0);
    check("b.SelectError", bus_b.SelectError, m_err[1]);
  endtask

  task automatic set_pattern();
    din[0] = 32'h11111111; din[1] = 32'h22222222;
    din[2] = 32'h33333333; din[3] = 32'h44444444;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_data[d] = 32'h0; m_chan[d] = 2'd0; m_err[d] = 1'b0;
    end
    for (int i = 0; i < 4; i++) din[i] = 32'h0;
    ctl = 2'd0; vin = 1'b0; ordy = 1'b0; fl = 1'b0; rst = 1'b1;
    apply();
    @(posedge CLK);
    #1;

    // reset, then idle
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    tick();
    check("idle.InReady", {63'd0, bus_a.InReady}, 64'd1);
    check("idle.DataOutput", bus_a.DataOutput, 64'd0);

    // basic select of channel 2
    set_pattern();
    ctl = 2'd2; vin = 1'b1; ordy = 1'b1;
    tick();
    check("sel2.DataOutput", bus_a.DataOutput, 64'h33333333);
    check("sel2.OutChannel", bus_a.OutChannel, 64'd2);

    // backpressure for 3 cycles while inputs toggle
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) din[j] = $urandom;
      ctl = 2'($urandom_range(0, 3));
      tick();
      check("hold.InReady", {63'd0, bus_a.InReady}, 64'd0);
      check("hold.DataOutput", bus_a.DataOutput, 64'h33333333);
    end

    // back-to-back with channel 3 (out of range for the 3-channel instance)
    set_pattern();
    ctl = 2'd3; vin = 1'b1; ordy = 1'b1;
    tick();
    check("b2b.DataOutput", bus_a.DataOutput, 64'h44444444);
    check("b2b.OutValid", {63'd0, bus_a.OutValid}, 64'd1);
    check("oor.DataOutput", bus_b.DataOutput, 64'd0);
    check("oor.SelectError", {63'd0, bus_b.SelectError}, {63'd0, RC});

    // flush + accept while full
    ctl = 2'd1; vin = 1'b1; ordy = 1'b1; fl = 1'b1;
    tick();
    check("flush.OutValid", {63'd0, bus_a.OutValid}, 64'd0);
    check("flush.SelectError", {63'd0, bus_b.SelectError}, {63'd0, RC});
    fl = 1'b0;

    // load, then drain without accept: data retained
    ctl = 2'd0; vin = 1'b1; ordy = 1'b0;
    tick();
    vin = 1'b0; ordy = 1'b1;
    tick();
    check("drain.OutValid", {63'd0, bus_a.OutValid}, 64'd0);
    check("drain.DataOutput", bus_a.DataOutput, 64'h11111111);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int j = 0; j < 4; j++) din[j] = $urandom;
      ctl  = 2'($urandom_range(0, 3));
      vin  = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      tick();
    end

    // reset while full and stalled
    rst = 1'b0; fl = 1'b0;
    set_pattern();
    ctl = 2'd3; vin = 1'b1; ordy = 1'b1;
    tick();
    vin = 1'b0; ordy = 1'b0; rst = 1'b1;
    tick();
    check("rstfull.OutValid", {63'd0, bus_a.OutValid}, 64'd0);
    check("rstfull.DataOutput", bus_a.DataOutput, 64'd0);
    check("rstfull.SelectError", {63'd0, bus_b.SelectError}, 64'd0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
